// File: rtl/conv_result_packer.sv
// Packs 8-bit conv results little-endian into 32-bit AXI-Stream words with TLAST/TKEEP tail handling.
// A small word FIFO decouples the byte datapath from M_AXIS backpressure.
package conv_result_packer_pkg;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEEP_W = WORD_W / 8;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } axis_word_t;
endpackage

module conv_result_packer
    import conv_result_packer_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNT_W                  = 20,
    parameter int unsigned FIFO_DEPTH             = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  total_bytes,
    input  logic                              in_valid,
    input  logic [7:0]                        in_data,
    output logic                              in_ready,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TVALID,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [3:0]                        M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TUSER,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    axis_word_t        mem_q [FIFO_DEPTH];
    axis_word_t        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              fifo_full_c;
    logic              pop_c;
    logic              accept_c;
    logic              last_byte_c;
    logic              push_c;
    logic [WORD_W-1:0] word_c;
    logic [KEEP_W-1:0] keep_c;
    axis_word_t        head_c;

    // Handshake and packing datapath; a full FIFO still accepts when the head pops this cycle
    always_comb begin
        fifo_full_c = (occ_q == OCC_W'(FIFO_DEPTH));
        pop_c       = (occ_q != OCC_W'(0)) && M_AXIS_TREADY;
        in_ready    = (state_q == PACK) && (!fifo_full_c || M_AXIS_TREADY);
        accept_c    = in_valid && in_ready;
        last_byte_c = (cnt_q == (total_q - CNT_W'(1)));
        push_c      = accept_c && ((lane_q == 2'd3) || last_byte_c);
        word_c      = pack_q | (WORD_W'(in_data) << {lane_q, 3'b000});
        head_c      = mem_q[rd_ptr_q];
        unique case (lane_q)
            2'd0:    keep_c = 4'b0001;
            2'd1:    keep_c = 4'b0011;
            2'd2:    keep_c = 4'b0111;
            default: keep_c = 4'b1111;
        endcase
    end

    // Next-state for FSM, counters, pack register and FIFO
    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    total_d = total_bytes;
                    cnt_d   = '0;
                    lane_d  = 2'd0;
                    pack_d  = '0;
                    state_d = (total_bytes == CNT_W'(0)) ? DONE : PACK;
                end
            end
            PACK: begin
                if (accept_c) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    lane_d = last_byte_c ? 2'd0 : lane_q + 2'd1;
                    pack_d = push_c ? '0 : word_c;
                    if (last_byte_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_c && head_c.last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push_c) begin
            mem_d[wr_ptr_q] = '{data: word_c, keep: keep_c, last: last_byte_c};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            total_q  <= '0;
            cnt_q    <= '0;
            lane_q   <= 2'd0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            pack_q   <= pack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

    assign M_AXIS_TVALID = (occ_q != OCC_W'(0));
    assign M_AXIS_TDATA  = head_c.data;
    assign M_AXIS_TKEEP  = head_c.keep;
    assign M_AXIS_TLAST  = head_c.last;
    assign M_AXIS_TUSER  = 1'b0;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_conv_result_packer.sv
// Directed self-checking bench for conv_result_packer: framing, tails, backpressure, reset abort, start ignore.
module tb_conv_result_packer;
    import conv_result_packer_pkg::*;

    localparam int unsigned CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] total_bytes;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             m_tready;
    logic             m_tvalid;
    logic [31:0]      m_tdata;
    logic [3:0]       m_tkeep;
    logic             m_tlast;
    logic             m_tuser;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    axis_word_t beats [$];
    int         done_cnt  = 0;
    int         cyc       = 0;
    int         tlast_cyc = 0;
    int         done_cyc  = 0;
    int         bi        = 0;
    int         exp_done  = 0;

    conv_result_packer #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .CNT_W(CNT_W),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .total_bytes(total_bytes),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .M_AXIS_TREADY(m_tready),
        .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TDATA(m_tdata),
        .M_AXIS_TKEEP(m_tkeep),
        .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TUSER(m_tuser),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Beat and done recorder, sampled mid-cycle when inputs are stable
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                beats.push_back('{data: m_tdata, keep: m_tkeep, last: m_tlast});
                if (m_tlast) tlast_cyc = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        if (bi >= beats.size()) begin
            chk({tag, "_missing"}, 32'(beats.size()), 32'(bi + 1));
        end else begin
            chk({tag, "_data"}, beats[bi].data, d);
            chk({tag, "_keep"}, 32'(beats[bi].keep), 32'(k));
            chk({tag, "_last"}, 32'(beats[bi].last), 32'(l));
        end
        bi++;
    endtask

    // Steps begin and end at posedge+1
    task automatic pulse_start(input int unsigned n);
        start       = 1'b1;
        total_bytes = CNT_W'(n);
        @(posedge clk); #1;
        start       = 1'b0;
        total_bytes = CNT_W'(0);
    endtask

    task automatic feed(input logic [7:0] first, input int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 500) begin
            in_valid = 1'b1;
            in_data  = first + 8'(i);
            @(negedge clk);
            if (in_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("feed_count", 32'(i), 32'(n));
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        exp_done++;
        while (done_cnt < exp_done && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk(tag, 32'(done_cnt), 32'(exp_done));
        @(posedge clk); #1;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        total_bytes = '0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        m_tready    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);
        @(posedge clk); #1;

        // T1: 8 bytes, two full words
        pulse_start(8);
        chk("t1_busy", 32'(busy), 32'd1);
        feed(8'h01, 8);
        wait_done("t1_done");
        chk("t1_done_lat", 32'(done_cyc - tlast_cyc), 32'd1);
        chk_beat("t1_w0", 32'h04030201, 4'hF, 1'b0);
        chk_beat("t1_w1", 32'h08070605, 4'hF, 1'b1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // T2: 6 bytes, padded tail
        pulse_start(6);
        feed(8'h11, 6);
        wait_done("t2_done");
        chk_beat("t2_w0", 32'h14131211, 4'hF, 1'b0);
        chk_beat("t2_w1", 32'h00001615, 4'h3, 1'b1);
        chk("t2_beats", 32'(beats.size()), 32'd4);

        // T3: backpressure fills the FIFO, head must hold
        m_tready = 1'b0;
        pulse_start(16);
        feed(8'h21, 8);
        in_valid = 1'b1;
        in_data  = 8'h29;
        @(negedge clk);
        chk("t3_in_ready_full", 32'(in_ready), 32'd0);
        for (int c = 0; c < 20; c++) begin
            chk("t3_stall_tvalid", 32'(m_tvalid), 32'd1);
            chk("t3_stall_tdata", m_tdata, 32'h24232221);
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        feed(8'h29, 8);
        wait_done("t3_done");
        chk_beat("t3_w0", 32'h24232221, 4'hF, 1'b0);
        chk_beat("t3_w1", 32'h28272625, 4'hF, 1'b0);
        chk_beat("t3_w2", 32'h2C2B2A29, 4'hF, 1'b0);
        chk_beat("t3_w3", 32'h302F2E2D, 4'hF, 1'b1);

        // T4: zero-length frame
        pulse_start(0);
        @(negedge clk);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        chk("t4_done_after", 32'(done), 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_tvalid_after", 32'(m_tvalid), 32'd0);
        exp_done++;
        chk("t4_done_cnt", 32'(done_cnt), 32'(exp_done));
        @(posedge clk); #1;

        // T5: reset mid-frame discards everything
        m_tready = 1'b0;
        pulse_start(12);
        feed(8'h31, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_tdata", m_tdata, 32'h0);
        chk("t5_rst_tkeep", 32'(m_tkeep), 32'd0);
        chk("t5_rst_tlast", 32'(m_tlast), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        chk("t5_post_busy", 32'(busy), 32'd0);
        chk("t5_post_tvalid", 32'(m_tvalid), 32'd0);
        @(posedge clk); #1;
        pulse_start(4);
        feed(8'h41, 4);
        wait_done("t5_done");
        chk_beat("t5_w0", 32'h44434241, 4'hF, 1'b1);
        chk("t5_beats", 32'(beats.size()), 32'(bi));

        // T6: start mid-frame is ignored
        pulse_start(8);
        feed(8'h51, 3);
        pulse_start(4);
        feed(8'h54, 5);
        wait_done("t6_done");
        chk_beat("t6_w0", 32'h54535251, 4'hF, 1'b0);
        chk_beat("t6_w1", 32'h58575655, 4'hF, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_single_done", 32'(done_cnt), 32'(exp_done));
        chk("t6_beats", 32'(beats.size()), 32'(bi));
        chk("t6_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
